// File: rtl/cache_tb_pkg.sv
// Shared definitions for cache trace generators.
// Holds the FSM state codes, access-pattern codes, the RAM address window,
// and the 16-bit LFSR taps, seed and step function.
package cache_tb_pkg;

  // Address window of the cache under test; addresses wrap inside it.
  localparam int RAM_SIZE = 4096;
  localparam int ADDR_W   = $clog2(RAM_SIZE);

  // Trace FSM states.
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_RUN   = 3'd1;
  localparam logic [2:0] ST_DRAIN = 3'd2;
  localparam logic [2:0] ST_FIN   = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  // Access patterns; code 3 behaves like sequential.
  localparam logic [1:0] PAT_SEQ  = 2'd0;
  localparam logic [1:0] PAT_LOOP = 2'd1;
  localparam logic [1:0] PAT_RAND = 2'd2;

  // x^16+x^14+x^13+x^11 as a right-shifting Fibonacci LFSR:
  // feedback is the XOR of state bits 0, 2, 3 and 5.
  localparam logic [15:0] LFSR16_TAPS = 16'h002D;
  localparam logic [15:0] LFSR16_SEED = 16'hACE1;

  function automatic logic [15:0] lfsr16_next(input logic [15:0] s);
    return {^(s & LFSR16_TAPS), s[15:1]};
  endfunction

endpackage

// File: rtl/cache_trace_gen_if.sv
// Request/response bus between a trace generator and the cache under test.
//   address, data, mode, finish : request side, driven by the generator
//   two_sig_hit, dir_sig_hit    : hit flags, driven by the cache
interface cache_trace_gen_if;
  logic [31:0] address;
  logic [31:0] data;
  logic        mode;
  logic        finish;
  logic        two_sig_hit;
  logic        dir_sig_hit;

  modport master (output address, data, mode, finish,
                  input  two_sig_hit, dir_sig_hit);
  modport slave  (input  address, data, mode, finish,
                  output two_sig_hit, dir_sig_hit);
endinterface

// File: rtl/trace_lfsr16.sv
// 16-bit LFSR for random address patterns.
//   clk, reset : clock, asynchronous active-high reset (state = RESET_VAL)
//   load, seed : synchronous load of seed (has priority over enable)
//   enable     : advance one step
//   state      : current LFSR value
module trace_lfsr16
  import cache_tb_pkg::*;
#(
  parameter logic [15:0] RESET_VAL = LFSR16_SEED
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        enable,
  input  logic [15:0] seed,
  output logic [15:0] state
);

  // LFSR state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= RESET_VAL;
    end else if (load) begin
      state <= seed;
    end else if (enable) begin
      state <= lfsr16_next(state);
    end else begin
      state <= state;
    end
  end

endmodule

// File: rtl/cache_trace_gen.sv
// Programmable request initiator for the cache under test.
//   clk, reset            : clock, asynchronous active-high reset
//   start                 : level; begins a run from IDLE, must drop to rearm
//   pattern/base/stride   : access pattern, start address, address increment
//   count/passes/wr_mask  : requests per pass, pass count, write selection
//   req (master)          : address/data/mode/finish out, hit flags in
//   busy                  : high while running or draining
//   issued_cnt/skip_cnt/two_hit_cnt/dir_hit_cnt : saturating run statistics
module cache_trace_gen
  import cache_tb_pkg::*;
#(
  parameter int          CNT_W     = 16,
  parameter logic [15:0] LFSR_SEED = LFSR16_SEED
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        pattern,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W-1:0] stride,
  input  logic [CNT_W-1:0]  count,
  input  logic [7:0]        passes,
  input  logic [7:0]        wr_mask,
  cache_trace_gen_if.master req,
  output logic              busy,
  output logic [CNT_W-1:0]  issued_cnt,
  output logic [CNT_W-1:0]  skip_cnt,
  output logic [CNT_W-1:0]  two_hit_cnt,
  output logic [CNT_W-1:0]  dir_hit_cnt
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    return (en && (v != {CNT_W{1'b1}})) ? v + CNT_W'(1) : v;
  endfunction

  logic [2:0]        state_r, state_nx;
  logic              drain_r;
  logic [1:0]        pat_r;
  logic [ADDR_W-1:0] base_r, stride_r, acc_r;
  logic [CNT_W-1:0]  count_r, j_r;
  logic [7:0]        passes_r, pass_r, wr_mask_r;
  logic [15:0]       i_r;
  logic [1:0]        tok_r;
  logic [15:0]       lfsr_q;
  logic [3:0]        unused_lfsr;

  logic              launch, in_run, j_last, run_last;
  logic              cand_wr, cand_dup, issue;
  logic [ADDR_W-1:0] cand_addr;
  logic [31:0]       cand_addr32, cand_data;

  assign unused_lfsr = lfsr_q[15:12];
  assign launch      = (state_r == ST_IDLE) && start;
  assign in_run      = (state_r == ST_RUN);

  trace_lfsr16 #(.RESET_VAL(LFSR_SEED)) u_lfsr (
    .clk    (clk),
    .reset  (reset),
    .load   (launch),
    .enable (in_run),
    .seed   (LFSR_SEED),
    .state  (lfsr_q)
  );

  // acc_r tracks base + (index)*stride incrementally, so no multiplier or
  // modulo is needed; the loop pattern rewinds it at the end of each pass.
  assign j_last      = (j_r == count_r - CNT_W'(1));
  assign run_last    = j_last && (pass_r == passes_r - 8'd1);
  assign cand_addr   = (pat_r == PAT_RAND) ? base_r + lfsr_q[ADDR_W-1:0] : acc_r;
  assign cand_addr32 = {{(32-ADDR_W){1'b0}}, cand_addr};
  assign cand_wr     = (wr_mask_r != 8'd0) && ((i_r[7:0] & wr_mask_r) == wr_mask_r);
  assign cand_data   = cand_wr ? ({16'h0000, i_r} ^ 32'hA5A5_0000) : 32'h0000_0000;
  // The cache ignores a repeated request, so an identical candidate is skipped.
  assign cand_dup    = (cand_addr32 == req.address) && (cand_data == req.data) &&
                       (cand_wr == req.mode);
  assign issue       = in_run && !cand_dup;

  // Next-state logic of the run FSM.
  always_comb begin
    state_nx = state_r;
    case (state_r)
      ST_IDLE:  if (start) state_nx = (count == '0) ? ST_DRAIN : ST_RUN;
                else       state_nx = ST_IDLE;
      ST_RUN:   if (run_last) state_nx = ST_DRAIN;
                else          state_nx = ST_RUN;
      ST_DRAIN: if (drain_r) state_nx = ST_FIN;
                else         state_nx = ST_DRAIN;
      ST_FIN:   state_nx = ST_DONE;
      ST_DONE:  if (!start) state_nx = ST_IDLE;
                else        state_nx = ST_DONE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  // FSM state, status outputs, latched run configuration and indices.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      drain_r    <= 1'b0;
      busy       <= 1'b0;
      req.finish <= 1'b0;
      pat_r      <= PAT_SEQ;
      base_r     <= '0;
      stride_r   <= '0;
      acc_r      <= '0;
      count_r    <= '0;
      passes_r   <= 8'd1;
      wr_mask_r  <= 8'd0;
      i_r        <= 16'd0;
      j_r        <= '0;
      pass_r     <= 8'd0;
    end else begin
      state_r    <= state_nx;
      drain_r    <= (state_r == ST_DRAIN);
      busy       <= (state_nx == ST_RUN) || (state_nx == ST_DRAIN);
      req.finish <= (state_nx == ST_FIN);
      if (launch) begin
        pat_r     <= pattern;
        base_r    <= base;
        stride_r  <= stride;
        acc_r     <= base;
        count_r   <= count;
        passes_r  <= (passes == 8'd0) ? 8'd1 : passes;
        wr_mask_r <= wr_mask;
        i_r       <= 16'd0;
        j_r       <= '0;
        pass_r    <= 8'd0;
      end else if (in_run) begin
        i_r   <= i_r + 16'd1;
        acc_r <= ((pat_r == PAT_LOOP) && j_last) ? base_r : acc_r + stride_r;
        if (j_last) begin
          j_r    <= '0;
          pass_r <= pass_r + 8'd1;
        end else begin
          j_r    <= j_r + CNT_W'(1);
        end
      end else begin
        i_r <= i_r;
      end
    end
  end

  // Request registers and issue/skip statistics.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req.address <= 32'h0;
      req.data    <= 32'h0;
      req.mode    <= 1'b0;
      issued_cnt  <= '0;
      skip_cnt    <= '0;
    end else if (launch) begin
      issued_cnt  <= '0;
      skip_cnt    <= '0;
    end else if (issue) begin
      req.address <= cand_addr32;
      req.data    <= cand_data;
      req.mode    <= cand_wr;
      issued_cnt  <= sat_inc(issued_cnt, 1'b1);
    end else begin
      skip_cnt    <= sat_inc(skip_cnt, in_run);
    end
  end

  // Hit flags belong to the request issued two edges earlier; a token rides
  // alongside each issued request and gates the hit accumulation.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tok_r       <= 2'b00;
      two_hit_cnt <= '0;
      dir_hit_cnt <= '0;
    end else if (launch) begin
      tok_r       <= 2'b00;
      two_hit_cnt <= '0;
      dir_hit_cnt <= '0;
    end else begin
      tok_r       <= {tok_r[0], issue};
      two_hit_cnt <= sat_inc(two_hit_cnt, tok_r[1] && req.two_sig_hit);
      dir_hit_cnt <= sat_inc(dir_hit_cnt, tok_r[1] && req.dir_sig_hit);
    end
  end

endmodule
